// File: rtl/dual_issue_scheduler.sv
// Decode-stage issue controller for the dual-issue core: decides per cycle
// whether the decoded pair issues together, splits over two cycles, or holds.
module dual_issue_scheduler #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rt1_D,
  input  logic [REG_W-1:0] dst1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic [REG_W-1:0] rt2_D,
  input  logic [REG_W-1:0] dst2_D,
  input  logic             regwrite1_D,
  input  logic             mem1_D,
  input  logic             branch1_D,
  input  logic             regwrite2_D,
  input  logic             mem2_D,
  input  logic             branch2_D,
  input  logic             memread1_EX,
  input  logic             memread2_EX,
  input  logic [REG_W-1:0] dst1_EX,
  input  logic [REG_W-1:0] dst2_EX,
  input  logic             mispredict_EX,
  output logic             flush_D_1,
  output logic             flush_D_2,
  output logic             stall_F,
  output logic             split_o,
  output logic [CNT_W-1:0] dual_cnt,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic raw, waw, conflict;
  logic hit_ex1_i1, hit_ex1_i2, hit_ex2_i1, hit_ex2_i2;
  logic lu;
  logic inc_dual, inc_single, inc_stall;

  // Register 0 is hardwired, so a zero destination never forms a dependency.
  function automatic logic src_match(input logic [REG_W-1:0] d,
                                     input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (d != '0) && ((d == a) || (d == b));
  endfunction

  always_comb begin
    raw        = regwrite1_D && src_match(dst1_D, rs2_D, rt2_D);
    waw        = regwrite1_D && regwrite2_D && (dst1_D != '0) && (dst1_D == dst2_D);
    conflict   = raw || waw || (mem1_D && mem2_D) || (branch1_D && branch2_D);

    hit_ex1_i1 = memread1_EX && src_match(dst1_EX, rs1_D, rt1_D);
    hit_ex1_i2 = memread1_EX && src_match(dst1_EX, rs2_D, rt2_D);
    hit_ex2_i1 = memread2_EX && src_match(dst2_EX, rs1_D, rt1_D);
    hit_ex2_i2 = memread2_EX && src_match(dst2_EX, rs2_D, rt2_D);

    // In SPLIT inst1 already left, so only inst2's sources matter.
    if (state == PAIR)
      lu = hit_ex1_i1 || hit_ex1_i2 || hit_ex2_i1 || hit_ex2_i2;
    else
      lu = hit_ex1_i2 || hit_ex2_i2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PAIR;
    else        state <= state_nxt;
  end

  always_comb begin
    flush_D_1  = 1'b1;
    flush_D_2  = 1'b1;
    stall_F    = 1'b0;
    state_nxt  = state;
    inc_dual   = 1'b0;
    inc_single = 1'b0;
    inc_stall  = 1'b0;
    if (!reset) begin
      state_nxt = PAIR;
    end else if (mispredict_EX) begin
      state_nxt = PAIR;
    end else if (!id_valid) begin
      state_nxt = state;
    end else if (lu) begin
      stall_F   = 1'b1;
      inc_stall = 1'b1;
    end else if (state == PAIR) begin
      if (conflict) begin
        flush_D_1  = 1'b0;
        stall_F    = 1'b1;
        state_nxt  = SPLIT;
        inc_single = 1'b1;
      end else begin
        flush_D_1 = 1'b0;
        flush_D_2 = 1'b0;
        inc_dual  = 1'b1;
      end
    end else begin
      flush_D_2  = 1'b0;
      state_nxt  = PAIR;
      inc_single = 1'b1;
    end
  end

  assign split_o = (state == SPLIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dual_cnt   <= '0;
      single_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (inc_dual && (dual_cnt != '1))     dual_cnt   <= dual_cnt + CNT_W'(1);
      if (inc_single && (single_cnt != '1)) single_cnt <= single_cnt + CNT_W'(1);
      if (inc_stall && (stall_cnt != '1))   stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler; expected values are hand-derived.
module tb_dual_issue_scheduler;
  localparam int CNT_W = 16;
  localparam int REG_W = 5;

  logic clk, reset, id_valid;
  logic [REG_W-1:0] rs1_D, rt1_D, dst1_D, rs2_D, rt2_D, dst2_D, dst1_EX, dst2_EX;
  logic regwrite1_D, mem1_D, branch1_D, regwrite2_D, mem2_D, branch2_D;
  logic memread1_EX, memread2_EX, mispredict_EX;
  logic flush_D_1, flush_D_2, stall_F, split_o;
  logic [CNT_W-1:0] dual_cnt, single_cnt, stall_cnt;
  logic [CNT_W-1:0] ed, es, est;
  int tests = 0;
  int fails = 0;

  dual_issue_scheduler #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .rs1_D(rs1_D), .rt1_D(rt1_D), .dst1_D(dst1_D),
    .rs2_D(rs2_D), .rt2_D(rt2_D), .dst2_D(dst2_D),
    .regwrite1_D(regwrite1_D), .mem1_D(mem1_D), .branch1_D(branch1_D),
    .regwrite2_D(regwrite2_D), .mem2_D(mem2_D), .branch2_D(branch2_D),
    .memread1_EX(memread1_EX), .memread2_EX(memread2_EX),
    .dst1_EX(dst1_EX), .dst2_EX(dst2_EX), .mispredict_EX(mispredict_EX),
    .flush_D_1(flush_D_1), .flush_D_2(flush_D_2), .stall_F(stall_F), .split_o(split_o),
    .dual_cnt(dual_cnt), .single_cnt(single_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {flush_D_1, flush_D_2, stall_F, split_o}
  function automatic logic [3:0] ctl();
    return {flush_D_1, flush_D_2, stall_F, split_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // add $3,$1,$2 paired with sub $5,$6,$7; no EX loads
  task automatic base();
    id_valid = 1'b1;
    rs1_D = 5'd1; rt1_D = 5'd2; dst1_D = 5'd3; regwrite1_D = 1'b1; mem1_D = 1'b0; branch1_D = 1'b0;
    rs2_D = 5'd6; rt2_D = 5'd7; dst2_D = 5'd5; regwrite2_D = 1'b1; mem2_D = 1'b0; branch2_D = 1'b0;
    memread1_EX = 1'b0; memread2_EX = 1'b0; dst1_EX = '0; dst2_EX = '0; mispredict_EX = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    base();
    id_valid = 1'b0;
    #2;
    tests++;
    if (ctl() !== 4'b1100) begin
      fails++; $display("FAIL reset_ctl got=%b exp=1100", ctl());
    end
    tests++;
    if ({dual_cnt, single_cnt, stall_cnt} !== '0) begin
      fails++; $display("FAIL reset_cnt got=%h/%h/%h exp=0/0/0", dual_cnt, single_cnt, stall_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    ed = '0; es = '0; est = '0;
  endtask

  task automatic test_dual();
    base(); #1;
    tests++;
    if (ctl() !== 4'b0000) begin
      fails++; $display("FAIL dual_ctl got=%b exp=0000", ctl());
    end
    tick(); ed++;
    tests++;
    if (dual_cnt !== ed) begin
      fails++; $display("FAIL dual_cnt got=%0d exp=%0d", dual_cnt, ed);
    end
  endtask

  // kind 0 RAW, 1 WAW, 2 mem, 3 branch: each must split over two cycles
  task automatic test_conflicts();
    for (int k = 0; k < 4; k++) begin
      base();
      case (k)
        0: rs2_D = 5'd3;
        1: dst2_D = 5'd3;
        2: begin mem1_D = 1'b1; mem2_D = 1'b1; end
        default: begin branch1_D = 1'b1; branch2_D = 1'b1; end
      endcase
      #1;
      tests++;
      if (ctl() !== 4'b0110) begin
        fails++; $display("FAIL conflict%0d_cycN got=%b exp=0110", k, ctl());
      end
      tick(); es++;
      tests++;
      if (ctl() !== 4'b1001) begin
        fails++; $display("FAIL conflict%0d_cycN1 got=%b exp=1001", k, ctl());
      end
      tick(); es++;
      tests++;
      if (split_o !== 1'b0 || single_cnt !== es || dual_cnt !== ed) begin
        fails++; $display("FAIL conflict%0d_after split=%b single=%0d dual=%0d exp 0/%0d/%0d",
                          k, split_o, single_cnt, dual_cnt, es, ed);
      end
    end
  endtask

  task automatic test_load_use();
    base(); rt2_D = 5'd8; memread1_EX = 1'b1; dst1_EX = 5'd8; #1;
    tests++;
    if (ctl() !== 4'b1110) begin
      fails++; $display("FAIL lu_slot1_ctl got=%b exp=1110", ctl());
    end
    tick(); est++;
    memread1_EX = 1'b0; #1;
    tests++;
    if (ctl() !== 4'b0000 || stall_cnt !== est) begin
      fails++; $display("FAIL lu_release ctl=%b stall_cnt=%0d exp 0000/%0d", ctl(), stall_cnt, est);
    end
    tick(); ed++;
    // load to $0 matching a $0 source never stalls
    rt2_D = 5'd0; memread1_EX = 1'b1; dst1_EX = 5'd0; #1;
    tests++;
    if (ctl() !== 4'b0000) begin
      fails++; $display("FAIL lu_zero_ctl got=%b exp=0000", ctl());
    end
    tick(); ed++;
    base(); memread2_EX = 1'b1; dst2_EX = 5'd1; #1;
    tests++;
    if (ctl() !== 4'b1110) begin
      fails++; $display("FAIL lu_slot2_ctl got=%b exp=1110", ctl());
    end
    tick(); est++;
    memread2_EX = 1'b0; tick(); ed++;
    tests++;
    if ({dual_cnt, single_cnt, stall_cnt} !== {ed, es, est}) begin
      fails++; $display("FAIL lu_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                        dual_cnt, single_cnt, stall_cnt, ed, es, est);
    end
  endtask

  task automatic test_split_lu();
    base(); dst1_D = 5'd4; rs2_D = 5'd4;
    tick(); es++;
    memread1_EX = 1'b1; dst1_EX = 5'd1; #1;
    tests++;
    if (ctl() !== 4'b1001) begin
      fails++; $display("FAIL split_lu_inst1_src got=%b exp=1001", ctl());
    end
    tick(); es++;
    memread1_EX = 1'b0;
    tick(); es++;
    memread1_EX = 1'b1; dst1_EX = 5'd7; #1;
    tests++;
    if (ctl() !== 4'b1111) begin
      fails++; $display("FAIL split_lu_hold got=%b exp=1111", ctl());
    end
    tick(); est++;
    tests++;
    if (split_o !== 1'b1 || stall_cnt !== est) begin
      fails++; $display("FAIL split_lu_stay split=%b stall=%0d exp 1/%0d", split_o, stall_cnt, est);
    end
    memread1_EX = 1'b0; tick(); es++;
    tests++;
    if (split_o !== 1'b0 || single_cnt !== es) begin
      fails++; $display("FAIL split_lu_exit split=%b single=%0d exp 0/%0d", split_o, single_cnt, es);
    end
  endtask

  task automatic test_mispredict();
    base(); dst1_D = 5'd4; rs2_D = 5'd4;
    tick(); es++;
    mispredict_EX = 1'b1; memread1_EX = 1'b1; dst1_EX = 5'd4; #1;
    tests++;
    if (ctl() !== 4'b1101) begin
      fails++; $display("FAIL mispredict_split_ctl got=%b exp=1101", ctl());
    end
    tick();
    tests++;
    if (split_o !== 1'b0 || {dual_cnt, single_cnt, stall_cnt} !== {ed, es, est}) begin
      fails++; $display("FAIL mispredict_after split=%b cnt=%0d/%0d/%0d exp 0/%0d/%0d/%0d",
                        split_o, dual_cnt, single_cnt, stall_cnt, ed, es, est);
    end
    base(); mispredict_EX = 1'b1; #1;
    tests++;
    if (ctl() !== 4'b1100) begin
      fails++; $display("FAIL mispredict_pair_ctl got=%b exp=1100", ctl());
    end
    tick();
    tests++;
    if (dual_cnt !== ed) begin
      fails++; $display("FAIL mispredict_pair_cnt got=%0d exp=%0d", dual_cnt, ed);
    end
  endtask

  task automatic test_invalid();
    base(); id_valid = 1'b0; #1;
    tests++;
    if (ctl() !== 4'b1100) begin
      fails++; $display("FAIL invalid_pair_ctl got=%b exp=1100", ctl());
    end
    tick();
    base(); dst1_D = 5'd4; rs2_D = 5'd4;
    tick(); es++;
    id_valid = 1'b0; #1;
    tests++;
    if (ctl() !== 4'b1101) begin
      fails++; $display("FAIL invalid_split_ctl got=%b exp=1101", ctl());
    end
    tick();
    tests++;
    if (split_o !== 1'b1 || {dual_cnt, single_cnt, stall_cnt} !== {ed, es, est}) begin
      fails++; $display("FAIL invalid_split_hold split=%b cnt=%0d/%0d/%0d exp 1/%0d/%0d/%0d",
                        split_o, dual_cnt, single_cnt, stall_cnt, ed, es, est);
    end
    id_valid = 1'b1; tick(); es++;
    tests++;
    if (split_o !== 1'b0 || single_cnt !== es) begin
      fails++; $display("FAIL invalid_split_resume split=%b single=%0d exp 0/%0d", split_o, single_cnt, es);
    end
  endtask

  task automatic test_reset_mid_split();
    base(); mem1_D = 1'b1; mem2_D = 1'b1;
    tick(); es++;
    tests++;
    if (split_o !== 1'b1 || single_cnt !== es) begin
      fails++; $display("FAIL stores_split split=%b single=%0d exp 1/%0d", split_o, single_cnt, es);
    end
    reset = 1'b0; #1;
    tests++;
    if (ctl() !== 4'b1100 || {dual_cnt, single_cnt, stall_cnt} !== '0) begin
      fails++; $display("FAIL reset_mid_split ctl=%b cnt=%0d/%0d/%0d exp 1100/0/0/0",
                        ctl(), dual_cnt, single_cnt, stall_cnt);
    end
    id_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    ed = '0; es = '0; est = '0;
  endtask

  task automatic test_saturation();
    base();
    repeat (65535) tick();
    ed = '1;
    tests++;
    if (dual_cnt !== ed) begin
      fails++; $display("FAIL sat_reach got=%h exp=%h", dual_cnt, ed);
    end
    tick();
    tests++;
    if (dual_cnt !== ed || single_cnt !== es || stall_cnt !== est) begin
      fails++; $display("FAIL sat_hold got=%h/%h/%h exp=%h/%h/%h",
                        dual_cnt, single_cnt, stall_cnt, ed, es, est);
    end
  endtask

  initial begin
    test_reset();
    test_dual();
    test_conflicts();
    test_load_use();
    test_split_lu();
    test_mispredict();
    test_invalid();
    test_reset_mid_split();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
